// File: rtl/cpu_dbg_mem_access.sv
// cpu_dbg_mem_access
// JTAG debug memory-access engine on the CPU clock. It takes the synchronised
// jdo word and the ocimem take-action pulses, and runs one Avalon-MM read or
// write at a time. Read data and status go back to the TCK-side capture register.
//
// Optional build feature: define CPU_DBG_MEM_AUTOINC_EN to enable address
// auto-increment. When it is enabled, jdo[35] on an a-pulse arms +4 after
// every successful completion. When it is not defined, jdo[35] is used only
// as a byte-enable bit on b-pulses.
module cpu_dbg_mem_access #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid
);

    // Timeout counter wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_WR_REQ  = 2'd3;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  tmo_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        be_reg;
    logic [31:0]       mon_data_reg;
    logic              ready_reg;
    logic              error_reg;

    // Command decode with fixed priority: a > no_action_a > b.
    logic              cmd_a;
    logic              cmd_na;
    logic              cmd_b;
    logic              read_now;
    logic [ADDR_W-1:0] jdo_addr;
    logic              is_idle;
    logic              rd_start;
    logic              wr_start;
    logic              busy_cmd;

    // Bus handshake outcomes for the current cycle.
    logic              rd_done;
    logic              wr_done;
    logic              xfer_done;
    logic              timed_out;
    logic              addr_step;

    // jdo[37:36] carry no meaning for this engine.
    logic              unused_jdo_hi;
    assign unused_jdo_hi = ^jdo[37:36];

    assign cmd_a    = take_action_ocimem_a;
    assign cmd_na   = !take_action_ocimem_a && take_no_action_ocimem_a;
    assign cmd_b    = !take_action_ocimem_a && !take_no_action_ocimem_a
                      && take_action_ocimem_b;
    assign read_now = jdo[34];
    assign jdo_addr = {jdo[ADDR_W-1:2], 2'b00};
    assign is_idle  = (state_reg == ST_IDLE);

    // A new transaction can only start from IDLE.
    assign rd_start = is_idle && ((cmd_a && read_now) || cmd_na);
    assign wr_start = is_idle && cmd_b;

    // Read or write pulses that arrive while a transaction is still running
    // are dropped and flagged. An a-pulse is never an error.
    assign busy_cmd = !is_idle && (cmd_na || cmd_b);

    // A read can finish in RD_REQ when the accept and the data arrive together.
    assign rd_done  = ((state_reg == ST_RD_REQ) && !m_waitrequest && m_readdatavalid)
                      || ((state_reg == ST_RD_WAIT) && m_readdatavalid);
    assign wr_done  = (state_reg == ST_WR_REQ) && !m_waitrequest;
    assign xfer_done = rd_done || wr_done;

    // The abort fires in the TIMEOUT_CYCLES-th busy cycle, unless that same
    // cycle completes the transfer normally.
    assign timed_out = !is_idle && (tmo_cnt_reg == CNT_LAST) && !xfer_done;

`ifdef CPU_DBG_MEM_AUTOINC_EN
    logic autoinc_reg;

    // Arm or disarm auto-increment whenever a new address is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            autoinc_reg <= 1'b0;
        end else if (cmd_a) begin
            autoinc_reg <= jdo[35];
        end
    end

    assign addr_step = autoinc_reg && xfer_done;
`else
    assign addr_step = 1'b0;
`endif

    // Next-state selection for the single-transaction engine.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd_start) begin
                    state_next = ST_RD_REQ;
                end else if (wr_start) begin
                    state_next = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (timed_out || rd_done) begin
                    state_next = ST_IDLE;
                end else if (!m_waitrequest) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (timed_out || rd_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (timed_out || wr_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register. A reset drops any request on the next edge, and IDLE
    // ignores readdatavalid responses that arrive later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Busy-cycle counter, restarted at the start of each transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
        end else if (rd_start || wr_start) begin
            tmo_cnt_reg <= '0;
        end else if (!is_idle) begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
        end
    end

    // Host-visible address pointer. A fresh load beats an auto-increment that
    // lands on the same edge. The increment wraps modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (cmd_a) begin
            addr_reg <= jdo_addr;
        end else if (addr_step) begin
            addr_reg <= addr_reg + ADDR_W'(4);
        end
    end

    // Bus address captured at transaction start. It stays stable through
    // stalls even if the host reloads the pointer mid-transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_reg <= '0;
        end else if (rd_start || wr_start) begin
            req_addr_reg <= cmd_a ? jdo_addr : addr_reg;
        end
    end

    // Write payload is latched only when a write actually starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_reg <= '0;
            be_reg    <= '0;
        end else if (wr_start) begin
            wdata_reg <= jdo[31:0];
            be_reg    <= jdo[35:32];
        end
    end

    // Read data capture. A timeout leaves the previous value in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_data_reg <= '0;
        end else if (rd_done) begin
            mon_data_reg <= m_readdata;
        end
    end

    // Ready drops when a transaction starts and rises when it completes or aborts.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg <= 1'b0;
        end else if (rd_start || wr_start) begin
            ready_reg <= 1'b0;
        end else if (xfer_done || timed_out) begin
            ready_reg <= 1'b1;
        end
    end

    // Sticky error flag. It is set by an abort or a busy collision and cleared
    // by an a-pulse. If an abort and an a-pulse land on the same edge, the
    // abort wins so the failure is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_reg <= 1'b0;
        end else if (timed_out || busy_cmd) begin
            error_reg <= 1'b1;
        end else if (cmd_a) begin
            error_reg <= 1'b0;
        end
    end

    assign MonDReg       = mon_data_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;
    assign m_address     = req_addr_reg;
    assign m_read        = (state_reg == ST_RD_REQ);
    assign m_write       = (state_reg == ST_WR_REQ);
    assign m_writedata   = wdata_reg;
    assign m_byteenable  = be_reg;

endmodule

// File: tb/tb_cpu_dbg_mem_access.sv
// Testbench for cpu_dbg_mem_access. It runs directed scenarios and then a
// randomized transaction stream, and checks each against a transaction-level
// model of the host-visible state. CPU_DBG_MEM_AUTOINC_EN selects which
// auto-increment behaviour the bench expects.
module tb_cpu_dbg_mem_access;

    localparam int TO = 8;

`ifdef CPU_DBG_MEM_AUTOINC_EN
    localparam bit AI_EN = 1'b1;
`else
    localparam bit AI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        m_readdatavalid;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the host-visible state.
    logic [31:0] mdl_addr;
    logic [31:0] mdl_mon;
    logic [31:0] mdl_wdata;
    logic [3:0]  mdl_be;
    bit          mdl_autoinc;
    bit          mdl_err;
    bit          mdl_ready;

    cpu_dbg_mem_access #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .MonDReg(MonDReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error),
        .m_address(m_address),
        .m_read(m_read),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_byteenable(m_byteenable),
        .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic [31:0] addr, input bit rn, input bit ai);
        logic [1:0] junk_hi;
        logic [1:0] junk_mid;
        junk_hi  = 2'($urandom_range(0, 3));
        junk_mid = 2'($urandom_range(0, 3));
        return {junk_hi, ai, rn, junk_mid, addr};
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data, input logic [3:0] be);
        logic [1:0] junk_hi;
        junk_hi = 2'($urandom_range(0, 3));
        return {junk_hi, be, data};
    endfunction

    // Drive one cycle of pulses, then return to idle inputs with a junk jdo.
    task automatic pulse(input bit pa, input bit pna, input bit pb, input logic [37:0] word);
        jdo = word;
        take_action_ocimem_a = pa;
        take_no_action_ocimem_a = pna;
        take_action_ocimem_b = pb;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        jdo = 38'({$urandom(), $urandom()});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mdl_addr = '0; mdl_mon = '0; mdl_wdata = '0; mdl_be = '0;
        mdl_autoinc = 1'b0; mdl_err = 1'b0; mdl_ready = 1'b0;
    endtask

    // Slave side of one read. Called the cycle after the command pulse.
    // It stalls for n_wait cycles, then returns data n_lat cycles after the accept.
    task automatic serve_read(input int n_wait, input int n_lat, input logic [31:0] data,
                              output logic [31:0] obs_addr, output int obs_req,
                              output bit obs_stable, output bit obs_ready_low);
        int last;
        obs_addr = m_address; obs_req = 0; obs_stable = 1'b1; obs_ready_low = 1'b1;
        last = n_wait + n_lat;
        for (int c = 0; c <= last; c++) begin
            if (m_read === 1'b1) begin
                obs_req++;
                if (m_address !== obs_addr) obs_stable = 1'b0;
            end
            if (monitor_ready !== 1'b0) obs_ready_low = 1'b0;
            m_readdata = $urandom;
            if (c < n_wait) begin
                m_waitrequest = 1'b1; m_readdatavalid = 1'b0;
            end else if (c == n_wait) begin
                m_waitrequest = 1'b0;
                m_readdatavalid = (n_lat == 0);
                if (n_lat == 0) m_readdata = data;
            end else begin
                m_waitrequest = 1'b1;
                m_readdatavalid = (c == last);
                if (c == last) m_readdata = data;
            end
            tick();
        end
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
    endtask

    // Slave side of one write, stalled for n_wait cycles.
    task automatic serve_write(input int n_wait,
                               output logic [31:0] obs_addr, output logic [31:0] obs_data,
                               output logic [3:0] obs_be, output int obs_req,
                               output bit obs_stable, output bit obs_ready_low);
        obs_addr = m_address; obs_data = m_writedata; obs_be = m_byteenable;
        obs_req = 0; obs_stable = 1'b1; obs_ready_low = 1'b1;
        for (int c = 0; c <= n_wait; c++) begin
            if (m_write === 1'b1) begin
                obs_req++;
                if (m_address !== obs_addr || m_writedata !== obs_data || m_byteenable !== obs_be)
                    obs_stable = 1'b0;
            end
            if (monitor_ready !== 1'b0) obs_ready_low = 1'b0;
            m_waitrequest = (c < n_wait);
            tick();
        end
        m_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        $display("test_reset: outputs after reset");
        checks++;
        if (MonDReg !== 32'h0 || m_writedata !== 32'h0) begin
            errors++; $display("FAIL reset_data: MonDReg=%h m_writedata=%h required 0", MonDReg, m_writedata);
        end
        checks++;
        if ({monitor_ready, monitor_error, m_read, m_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: ready/error/read/write=%b required 0000",
                               {monitor_ready, monitor_error, m_read, m_write});
        end
        checks++;
        if (m_address !== 32'h0 || m_byteenable !== 4'h0) begin
            errors++; $display("FAIL reset_addr_be: m_address=%h be=%h required 0", m_address, m_byteenable);
        end
        // Reset during a stalled read, then a late response must be ignored.
        pulse(1, 0, 0, mk_a(32'h40, 1'b1, 1'b0));
        m_waitrequest = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (m_read !== 1'b0) begin
            errors++; $display("FAIL reset_mid_read: m_read=%b required 0", m_read);
        end
        reset = 1'b0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'h1234_5678;
        tick();
        m_readdatavalid = 1'b0;
        checks++;
        if (MonDReg !== 32'h0 || monitor_ready !== 1'b0) begin
            errors++; $display("FAIL reset_late_valid: MonDReg=%h ready=%b required 0/0", MonDReg, monitor_ready);
        end
        do_reset();
    endtask

    task automatic test_read_directed();
        logic [31:0] oa; int oreq; bit ostab; bit olow;
        do_reset();
        pulse(1, 0, 0, mk_a(32'h0000_1000, 1'b1, 1'b0));
        serve_read(0, 1, 32'hDEAD_BEEF, oa, oreq, ostab, olow);
        $display("test_read_directed: addr=%h MonDReg=%h ready=%b", oa, MonDReg, monitor_ready);
        checks++;
        if (oa !== 32'h0000_1000 || oreq != 1) begin
            errors++; $display("FAIL dir_read_req: addr=%h req_cycles=%0d required 00001000/1", oa, oreq);
        end
        checks++;
        if (olow !== 1'b1 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL dir_read_latency: ready_low_before=%b ready_at_3=%b required 1/1", olow, monitor_ready);
        end
        checks++;
        if (MonDReg !== 32'hDEAD_BEEF || monitor_error !== 1'b0) begin
            errors++; $display("FAIL dir_read_data: MonDReg=%h error=%b required deadbeef/0", MonDReg, monitor_error);
        end
        mdl_addr = 32'h0000_1000; mdl_mon = 32'hDEAD_BEEF; mdl_ready = 1'b1;
    endtask

    task automatic test_write_stall();
        logic [31:0] oa; logic [31:0] od; logic [3:0] ob; int oreq; bit ostab; bit olow;
        pulse(0, 0, 1, mk_b(32'hA5A5_5A5A, 4'b0011));
        serve_write(5, oa, od, ob, oreq, ostab, olow);
        $display("test_write_stall: addr=%h data=%h be=%b cycles=%0d", oa, od, ob, oreq);
        checks++;
        if (oreq != 6 || ostab !== 1'b1) begin
            errors++; $display("FAIL wr_stall_hold: write_cycles=%0d stable=%b required 6/1", oreq, ostab);
        end
        checks++;
        if (od !== 32'hA5A5_5A5A || ob !== 4'b0011 || oa !== mdl_addr) begin
            errors++; $display("FAIL wr_stall_payload: data=%h be=%b addr=%h required a5a55a5a/0011/%h", od, ob, oa, mdl_addr);
        end
        checks++;
        if (olow !== 1'b1 || monitor_ready !== 1'b1 || m_write !== 1'b0) begin
            errors++; $display("FAIL wr_stall_ready: ready_low=%b ready=%b m_write=%b required 1/1/0", olow, monitor_ready, m_write);
        end
        mdl_wdata = 32'hA5A5_5A5A; mdl_be = 4'b0011; mdl_ready = 1'b1;
    endtask

    task automatic test_timeout();
        logic [31:0] oa; int oreq; bit ostab; bit olow; int cnt;
        pulse(0, 1, 0, 38'h0);
        serve_read(1, 1, 32'h0BAD_F00D, oa, oreq, ostab, olow);
        mdl_mon = 32'h0BAD_F00D;
        // Read with the slave stalled indefinitely.
        pulse(0, 1, 0, 38'h0);
        m_waitrequest = 1'b1;
        cnt = 0;
        while (m_read === 1'b1 && cnt < 3 * TO) begin
            cnt++;
            tick();
        end
        m_waitrequest = 1'b0;
        $display("test_timeout: read held %0d cycles, error=%b", cnt, monitor_error);
        checks++;
        if (cnt != TO) begin
            errors++; $display("FAIL tmo_read_len: m_read cycles=%0d required %0d", cnt, TO);
        end
        checks++;
        if (monitor_error !== 1'b1 || monitor_ready !== 1'b1 || MonDReg !== mdl_mon) begin
            errors++; $display("FAIL tmo_read_status: error=%b ready=%b MonDReg=%h required 1/1/%h",
                               monitor_error, monitor_ready, MonDReg, mdl_mon);
        end
        pulse(1, 0, 0, mk_a(32'h0000_2000, 1'b0, 1'b0));
        checks++;
        if (monitor_error !== 1'b0 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL tmo_clear: error=%b ready=%b required 0/1", monitor_error, monitor_ready);
        end
        // Write with the slave stalled indefinitely.
        pulse(0, 0, 1, mk_b(32'h1111_2222, 4'hF));
        m_waitrequest = 1'b1;
        cnt = 0;
        while (m_write === 1'b1 && cnt < 3 * TO) begin
            cnt++;
            tick();
        end
        m_waitrequest = 1'b0;
        $display("test_timeout: write held %0d cycles, error=%b", cnt, monitor_error);
        checks++;
        if (cnt != TO || monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL tmo_write: cycles=%0d error=%b ready=%b required %0d/1/1",
                               cnt, monitor_error, monitor_ready, TO);
        end
        pulse(1, 0, 0, mk_a(32'h0000_2000, 1'b0, 1'b0));
        mdl_addr = 32'h0000_2000; mdl_wdata = 32'h1111_2222; mdl_be = 4'hF;
        mdl_err = 1'b0; mdl_ready = 1'b1; mdl_autoinc = 1'b0;
    endtask

    task automatic test_busy_cmd();
        do_reset();
        pulse(1, 0, 0, mk_a(32'h0000_0300, 1'b1, 1'b0));
        m_waitrequest = 1'b0;
        tick();                            // accepted, now waiting for data
        pulse(0, 1, 0, 38'h0);             // read command while busy
        checks++;
        if (monitor_error !== 1'b1 || m_read !== 1'b0) begin
            errors++; $display("FAIL busy_na_flag: error=%b m_read=%b required 1/0", monitor_error, m_read);
        end
        m_readdatavalid = 1'b1; m_readdata = 32'hCAFE_0001;
        tick();
        m_readdatavalid = 1'b0;
        $display("test_busy_cmd: read done MonDReg=%h error=%b", MonDReg, monitor_error);
        checks++;
        if (MonDReg !== 32'hCAFE_0001 || monitor_ready !== 1'b1 || monitor_error !== 1'b1 || m_read !== 1'b0) begin
            errors++; $display("FAIL busy_na_complete: MonDReg=%h ready=%b error=%b m_read=%b required cafe0001/1/1/0",
                               MonDReg, monitor_ready, monitor_error, m_read);
        end
        // A second write pulse during a stalled write.
        pulse(0, 0, 1, mk_b(32'h7777_0000, 4'b1000));
        m_waitrequest = 1'b1;
        pulse(0, 0, 1, mk_b(32'h8888_0000, 4'b0001));
        checks++;
        if (m_writedata !== 32'h7777_0000 || m_byteenable !== 4'b1000 || m_write !== 1'b1) begin
            errors++; $display("FAIL busy_b_hold: data=%h be=%b m_write=%b required 77770000/1000/1",
                               m_writedata, m_byteenable, m_write);
        end
        m_waitrequest = 1'b0;
        tick();
        checks++;
        if (monitor_ready !== 1'b1 || m_write !== 1'b0 || monitor_error !== 1'b1) begin
            errors++; $display("FAIL busy_b_complete: ready=%b m_write=%b error=%b required 1/0/1",
                               monitor_ready, m_write, monitor_error);
        end
        do_reset();
    endtask

    task automatic test_autoinc_wrap();
        logic [31:0] oa1; logic [31:0] oa2; logic [31:0] exp2; int oreq; bit ostab; bit olow;
        do_reset();
        pulse(1, 0, 0, mk_a(32'hFFFF_FFFE, 1'b0, 1'b1));
        pulse(0, 1, 0, 38'h0);
        serve_read(0, 1, 32'h0000_00A1, oa1, oreq, ostab, olow);
        pulse(0, 1, 0, 38'h0);
        serve_read(0, 1, 32'h0000_00A2, oa2, oreq, ostab, olow);
        exp2 = AI_EN ? 32'h0000_0000 : 32'hFFFF_FFFC;
        $display("test_autoinc_wrap: first=%h second=%h", oa1, oa2);
        checks++;
        if (oa1 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL autoinc_first: addr=%h required fffffffc", oa1);
        end
        checks++;
        if (oa2 !== exp2 || MonDReg !== 32'h0000_00A2) begin
            errors++; $display("FAIL autoinc_second: addr=%h MonDReg=%h required %h/000000a2", oa2, MonDReg, exp2);
        end
        do_reset();
    endtask

    task automatic test_priority();
        logic [31:0] oa; int oreq; bit ostab; bit olow;
        do_reset();
        jdo = mk_a(32'h0000_0200, 1'b1, 1'b0);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        checks++;
        if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 32'h0000_0200) begin
            errors++; $display("FAIL prio_cmd: m_read=%b m_write=%b addr=%h required 1/0/00000200", m_read, m_write, m_address);
        end
        serve_read(0, 0, 32'h5555_AAAA, oa, oreq, ostab, olow);
        $display("test_priority: read addr=%h MonDReg=%h", oa, MonDReg);
        checks++;
        if (MonDReg !== 32'h5555_AAAA || monitor_error !== 1'b0 || m_writedata !== 32'h0 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL prio_result: MonDReg=%h error=%b wdata=%h ready=%b required 5555aaaa/0/0/1",
                               MonDReg, monitor_error, m_writedata, monitor_ready);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] oa; logic [31:0] od; logic [3:0] ob; int oreq; bit ostab; bit olow;
        logic [31:0] addr; logic [31:0] data; logic [3:0] be;
        int op; int n_wait; int n_lat; bit ai;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 3);
            n_wait = $urandom_range(0, 3);
            n_lat = $urandom_range(0, 3);
            addr = $urandom;
            data = $urandom;
            be = 4'($urandom_range(0, 15));
            ai = 1'($urandom_range(0, 1));
            if (op == 0) begin
                pulse(1, 0, 0, mk_a(addr, 1'b0, ai));
                mdl_addr = addr & 32'hFFFF_FFFC; mdl_autoinc = AI_EN & ai; mdl_err = 1'b0;
                $display("txn %0d load addr=%h autoinc=%b", t, mdl_addr, mdl_autoinc);
                checks++;
                if (m_read !== 1'b0 || m_write !== 1'b0 || monitor_ready !== mdl_ready || monitor_error !== 1'b0) begin
                    errors++; $display("FAIL rnd_load t=%0d: read=%b write=%b ready=%b error=%b required 0/0/%b/0",
                                       t, m_read, m_write, monitor_ready, monitor_error, mdl_ready);
                end
            end else if (op == 1 || op == 2) begin
                if (op == 1) begin
                    pulse(1, 0, 0, mk_a(addr, 1'b1, ai));
                    mdl_addr = addr & 32'hFFFF_FFFC; mdl_autoinc = AI_EN & ai; mdl_err = 1'b0;
                end else begin
                    pulse(0, 1, 0, 38'({$urandom(), $urandom()}));
                end
                serve_read(n_wait, n_lat, data, oa, oreq, ostab, olow);
                $display("txn %0d read addr=%h data=%h wait=%0d lat=%0d", t, oa, MonDReg, n_wait, n_lat);
                checks++;
                if (oa !== mdl_addr || oreq != n_wait + 1 || ostab !== 1'b1) begin
                    errors++; $display("FAIL rnd_read_req t=%0d: addr=%h cycles=%0d stable=%b required %h/%0d/1",
                                       t, oa, oreq, ostab, mdl_addr, n_wait + 1);
                end
                checks++;
                if (MonDReg !== data || olow !== 1'b1 || monitor_ready !== 1'b1 || monitor_error !== mdl_err) begin
                    errors++; $display("FAIL rnd_read_done t=%0d: MonDReg=%h ready_low=%b ready=%b error=%b required %h/1/1/%b",
                                       t, MonDReg, olow, monitor_ready, monitor_error, data, mdl_err);
                end
                mdl_mon = data; mdl_ready = 1'b1;
                if (mdl_autoinc) mdl_addr = mdl_addr + 32'd4;
            end else begin
                pulse(0, 0, 1, mk_b(data, be));
                serve_write(n_wait, oa, od, ob, oreq, ostab, olow);
                $display("txn %0d write addr=%h data=%h be=%b wait=%0d", t, oa, od, ob, n_wait);
                checks++;
                if (oa !== mdl_addr || od !== data || ob !== be) begin
                    errors++; $display("FAIL rnd_write_payload t=%0d: addr=%h data=%h be=%b required %h/%h/%b",
                                       t, oa, od, ob, mdl_addr, data, be);
                end
                checks++;
                if (oreq != n_wait + 1 || ostab !== 1'b1 || olow !== 1'b1 || monitor_ready !== 1'b1 || monitor_error !== mdl_err) begin
                    errors++; $display("FAIL rnd_write_done t=%0d: cycles=%0d stable=%b ready_low=%b ready=%b error=%b required %0d/1/1/1/%b",
                                       t, oreq, ostab, olow, monitor_ready, monitor_error, n_wait + 1, mdl_err);
                end
                mdl_wdata = data; mdl_be = be; mdl_ready = 1'b1;
                if (mdl_autoinc) mdl_addr = mdl_addr + 32'd4;
            end
            // Idle gap with stray read responses that must not be captured.
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                m_readdatavalid = 1'($urandom_range(0, 1));
                m_readdata = $urandom;
                tick();
            end
            m_readdatavalid = 1'b0;
            checks++;
            if (MonDReg !== mdl_mon || m_writedata !== mdl_wdata) begin
                errors++; $display("FAIL rnd_idle t=%0d: MonDReg=%h wdata=%h required %h/%h", t, MonDReg, m_writedata, mdl_mon, mdl_wdata);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        m_readdata = '0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        test_reset();
        test_read_directed();
        test_write_stall();
        test_timeout();
        test_busy_cmd();
        test_autoinc_wrap();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
